// File: rtl/window_mac_ctrl.sv
// Loads one 3x3 image window from a valid/ready stream, then MACs it against the kernel window.
// Latency: 9 MAC cycles after the last accepted beat; result held on o_valid until i_ready.
module window_mac_ctrl #(
  parameter int WINDOW_ELEMNT_SIZE = 8,
  parameter int WINDOW_REG_SIZE    = 9,
  parameter int ADDR_SIZE          = 4,
  parameter int ACC_SIZE           = 20
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WINDOW_ELEMNT_SIZE-1:0] s_data,
  output logic                          wr_en,
  output logic [ADDR_SIZE-1:0]          wr_addr,
  output logic [WINDOW_ELEMNT_SIZE-1:0] wr_data,
  output logic [ADDR_SIZE-1:0]          rd_addr,
  input  logic [WINDOW_ELEMNT_SIZE-1:0] img_rd_data,
  input  logic [WINDOW_ELEMNT_SIZE-1:0] krn_rd_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [ACC_SIZE-1:0]           o_result,
  output logic                          o_busy
);

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(WINDOW_REG_SIZE - 1);
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

  state_t                          state, state_nxt;
  logic [ADDR_SIZE-1:0]            load_cnt, load_cnt_nxt, rd_addr_nxt;
  logic [ACC_SIZE-1:0]             acc, acc_nxt, result_nxt, sum;
  logic                            valid_nxt;
  logic [2*WINDOW_ELEMNT_SIZE-1:0] prod;

  assign prod    = (2*WINDOW_ELEMNT_SIZE)'(img_rd_data) * (2*WINDOW_ELEMNT_SIZE)'(krn_rd_data);
  assign sum     = acc + ACC_SIZE'(prod);
  assign wr_addr = load_cnt;
  assign wr_data = s_data;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      load_cnt <= '0;
      rd_addr  <= '0;
      acc      <= '0;
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      load_cnt <= load_cnt_nxt;
      rd_addr  <= rd_addr_nxt;
      acc      <= acc_nxt;
      o_result <= result_nxt;
      o_valid  <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_cnt_nxt = load_cnt;
    rd_addr_nxt  = rd_addr;
    acc_nxt      = acc;
    result_nxt   = o_result;
    valid_nxt    = o_valid;
    s_ready      = 1'b0;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt    = LOAD;
          load_cnt_nxt = '0;
          acc_nxt      = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        wr_en   = s_valid;
        if (s_valid) begin
          load_cnt_nxt = load_cnt + ADDR_ONE;
          if (load_cnt == LAST_IDX) begin
            state_nxt   = MAC;
            rd_addr_nxt = '0;
            acc_nxt     = '0;
          end
        end
      end
      MAC: begin
        acc_nxt = sum;
        if (rd_addr == LAST_IDX) begin
          // rd_addr parks on the last element until the result is taken
          result_nxt = sum;
          valid_nxt  = 1'b1;
          state_nxt  = DONE;
        end else begin
          rd_addr_nxt = rd_addr + ADDR_ONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_nxt   = 1'b0;
          rd_addr_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_mac_ctrl.sv
// Directed and random passes of window_mac_ctrl against a sum-of-products reference model.
module tb_window_mac_ctrl;
  localparam int W  = 8;
  localparam int N  = 9;
  localparam int AW = 4;
  localparam int AS = 20;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, s_valid, i_ready;
  logic [W-1:0]  s_data;
  logic          s_ready, wr_en, o_valid, o_busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data, img_rd_data, krn_rd_data;
  logic [AS-1:0] o_result;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  img_mem [16];
  logic [W-1:0]  krn_mem [16];
  logic [W-1:0]  img_vec [N];
  logic [AW-1:0] wa_q [$];
  logic [W-1:0]  wd_q [$];
  logic [AS-1:0] last_result;

  always #5 i_clk = ~i_clk;

  window_mac_ctrl #(
    .WINDOW_ELEMNT_SIZE(W), .WINDOW_REG_SIZE(N), .ADDR_SIZE(AW), .ACC_SIZE(AS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .img_rd_data(img_rd_data), .krn_rd_data(krn_rd_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy)
  );

  // Window registers: image written by the DUT, kernel set by the bench
  assign img_rd_data = img_mem[rd_addr];
  assign krn_rd_data = krn_mem[rd_addr];

  always @(posedge i_clk) begin
    if (wr_en) begin
      img_mem[wr_addr] <= wr_data;
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int ref_mac();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(img_vec[i]) * int'(krn_mem[i]);
    return s;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_o_valid"}, o_valid, 0);
    chk({tag, "_o_result"}, o_result, 0);
  endtask

  // mode: 0 continuous valid, 1 pattern 1,0,0, 2 random valid
  task automatic run_pass(input int mode, input int hold, input int abort_at, input bit poke);
    int  idx, c, exp;
    bit  v;
    exp = ref_mac();
    wa_q.delete();
    wd_q.delete();
    i_start = 1'b1;
    s_valid = 1'b0;
    tick();
    i_start = 1'b0;
    chk("busy_in_load", o_busy, 1);
    idx = 0;
    c   = 0;
    while (idx < N && c < 500) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = v ? img_vec[idx] : 8'($urandom);
      i_start = poke && (c == 2);
      #1;
      chk("load_s_ready", s_ready, 1);
      chk("load_wr_en", wr_en, v);
      if (v) chk("load_wr_addr", wr_addr, idx);
      tick();
      if (v) idx++;
      c++;
    end
    if (idx < N) chk("load_timeout", idx, N);
    s_valid = 1'b0;
    i_start = 1'b0;
    chk("wr_count", wa_q.size(), N);
    for (int i = 0; i < N && i < wa_q.size(); i++) begin
      chk("wr_log_addr", wa_q[i], i);
      chk("wr_log_data", wd_q[i], img_vec[i]);
    end
    for (int k = 0; k < N; k++) begin
      i_start = poke;
      s_valid = 1'($urandom_range(0, 1));
      #1;
      chk("mac_s_ready", s_ready, 0);
      chk("mac_wr_en", wr_en, 0);
      chk("mac_o_valid", o_valid, 0);
      chk("mac_rd_addr", rd_addr, k);
      chk("mac_result_held", o_result, last_result);
      if (k == abort_at) begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        s_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        chk_reset_outputs("abort");
        last_result = '0;
        for (int j = 0; j < 12; j++) begin
          tick();
          chk("abort_no_valid", o_valid, 0);
          chk("abort_idle", o_busy, 0);
        end
        return;
      end
      tick();
    end
    i_start = 1'b0;
    s_valid = 1'b0;
    chk("done_o_valid", o_valid, 1);
    chk("done_o_result", o_result, exp);
    last_result = AS'(exp);
    for (int h = 0; h < hold; h++) begin
      i_ready = 1'b0;
      i_start = poke;
      #1;
      chk("hold_o_valid", o_valid, 1);
      chk("hold_o_result", o_result, exp);
      chk("hold_busy", o_busy, 1);
      tick();
    end
    i_start = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("post_o_valid", o_valid, 0);
    chk("post_busy", o_busy, 0);
    chk("post_rd_addr", rd_addr, 0);
    chk("post_result_held", o_result, exp);
    tick();
    chk("post_no_restart", o_busy, 0);
  endtask

  initial begin
    int base_img [N] = '{3, 1, 5, 2, 4, 2, 5, 1, 3};
    int k_ctr    [N] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int k_gauss  [N] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    i_rst = 1'b1; i_start = 1'b0; s_valid = 1'b0; i_ready = 1'b0; s_data = '0;
    last_result = '0;
    for (int i = 0; i < 16; i++) krn_mem[i] = '0;
    tick(); tick(); tick();
    i_rst = 1'b0;
    chk_reset_outputs("reset");

    s_valid = 1'b1;
    #1;
    chk("idle_ignores_valid_wr_en", wr_en, 0);
    chk("idle_s_ready", s_ready, 0);
    tick();
    chk("idle_stays", o_busy, 0);
    s_valid = 1'b0;

    for (int i = 0; i < N; i++) begin img_vec[i] = 8'(base_img[i]); krn_mem[i] = 8'd1; end
    run_pass(0, 2, -1, 1'b0);

    for (int i = 0; i < N; i++) krn_mem[i] = 8'(k_ctr[i]);
    run_pass(0, 0, -1, 1'b0);

    for (int i = 0; i < N; i++) krn_mem[i] = 8'(k_gauss[i]);
    run_pass(1, 5, -1, 1'b1);

    for (int i = 0; i < N; i++) begin img_vec[i] = 8'hFF; krn_mem[i] = 8'hFF; end
    run_pass(0, 1, -1, 1'b0);

    for (int i = 0; i < N; i++) begin img_vec[i] = 8'($urandom); krn_mem[i] = 8'($urandom); end
    run_pass(0, 0, 3, 1'b0);

    for (int i = 0; i < N; i++) begin img_vec[i] = 8'(base_img[i]); krn_mem[i] = 8'($urandom); end
    run_pass(0, 1, -1, 1'b0);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++) begin img_vec[i] = 8'($urandom); krn_mem[i] = 8'($urandom); end
      run_pass(2, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1);
  end

endmodule
